mul16_sched: RTL and testbench
==============================

MUL16_SCHED -- requirements
Module: mul16_sched

Interface
REQ-001 The block SHALL have parameter PRIO_INIT, default 0, meaning which requester (0 or 1) holds round-robin priority after reset.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock, rising-edge active.
REQ-003 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 The block SHALL have port req0_valid, input, 1 bit: requester 0 has an operand pair.
REQ-005 The block SHALL have port req0_ready, output, 1 bit: requester 0 is accepted this cycle.
REQ-006 The block SHALL have ports req0_a and req0_b, inputs, 16 bits each: requester 0 unsigned operands.
REQ-007 The block SHALL have ports req1_valid (in, 1), req1_ready (out, 1), req1_a (in, 16) and req1_b (in, 16), identical in meaning for requester 1.
REQ-008 The block SHALL have port rsp_valid, output, 1 bit: result available.
REQ-009 The block SHALL have port rsp_ready, input, 1 bit: consumer accepts the result.
REQ-010 The block SHALL have port rsp_id, output, 1 bit: the requester the result belongs to.
REQ-011 The block SHALL have port rsp_p, output, 32 bits: the unsigned product.
REQ-012 The block SHALL have ports m_a and m_b, outputs, 8 bits each: operands driven to the shared external mul_8bit.
REQ-013 The block SHALL have port m_p, input, 16 bits: the combinational product returned by mul_8bit.
REQ-014 The block SHALL have port busy, output, 1 bit: high whenever the state is not IDLE.

Function
REQ-015 The block SHALL implement the FSM IDLE -> P0 -> P1 -> P2 -> P3 -> DONE -> IDLE.
REQ-016 In IDLE, the block SHALL assert reqN_ready combinationally only for the granted requester; the other requester's ready SHALL be 0, and both SHALL be 0 in every other state.
REQ-017 When only one requester is valid, it SHALL be granted; when both are valid, the requester not served last SHALL be granted.
REQ-018 The last-served pointer SHALL update only on an accepted handshake.
REQ-019 On an accept edge, the block SHALL latch the operands and the id, clear the accumulator and enter P0.
REQ-020 In each compute state, m_a/m_b SHALL be: P0 a[7:0]/b[7:0]; P1 a[15:8]/b[7:0]; P2 a[7:0]/b[15:8]; P3 a[15:8]/b[15:8]. In IDLE and DONE they SHALL be 0.
REQ-021 On the edge leaving each compute state, the accumulator SHALL update as: P0 acc=m_p; P1 acc+=m_p<<8; P2 acc+=m_p<<8; P3 acc+=m_p<<16; all arithmetic SHALL be mod 2^32.
REQ-022 rsp_valid SHALL be 1 exactly in DONE, starting 5 rising edges after the accept edge (4 compute cycles).
REQ-023 rsp_p and rsp_id SHALL be the latched accumulator and id, held stable while rsp_valid is high.
REQ-024 In DONE, the block SHALL wait indefinitely for rsp_ready; on rsp_valid&rsp_ready it SHALL return to IDLE.
REQ-025 No new request SHALL be accepted in the same cycle as the response handshake.
REQ-026 Request valids changing during P0..DONE SHALL have no effect.

Reset
REQ-027 While rst_n=0, asynchronously: state=IDLE, accumulator=0, latched operands=0, rsp_valid=0, rsp_id=0, rsp_p=0, busy=0, m_a=m_b=0, reqN_ready=0, and last-served pointer set so that PRIO_INIT wins the first tie.
REQ-028 Reset asserted mid-operation SHALL abandon the operation with no response issued.

Configuration
REQ-029 When macro MUL16_SCHED_ZERO_SKIP_EN is defined, an accepted request with req_a==0 or req_b==0 SHALL go directly IDLE -> DONE with rsp_p=0, so rsp_valid is high 1 edge after the accept edge.
REQ-030 When MUL16_SCHED_ZERO_SKIP_EN is undefined, every request SHALL take the full P0..P3 path.

Verification
REQ-031 The bench SHALL check: req0 a=0x1234, b=0x5678, rsp_ready=1 -> rsp_p=0x06260060, rsp_id=0, rsp_valid 5 edges after accept.
REQ-032 The bench SHALL check: req1 a=0xFFFF, b=0xFFFF -> rsp_p=0xFFFE0001, rsp_id=1.
REQ-033 The bench SHALL check: PRIO_INIT=0, both valid continuously with distinct operands -> serviced 0, 1, 0, 1, with rsp_id alternating and correct products.
REQ-034 The bench SHALL check: rsp_ready held low 3 cycles in DONE -> rsp_p/rsp_id stable, req ready low, busy=1; after release, IDLE is reached next edge.
REQ-035 The bench SHALL check: a=0x0000, b=0xABCD -> rsp_p=0; latency 1 edge with MUL16_SCHED_ZERO_SKIP_EN defined, 5 edges without.
REQ-036 The bench SHALL check: rst_n pulsed low during P2 -> all outputs reset immediately, no response; the next request completes correctly.

Source files
------------

// File: rtl/mul16_sched.sv
// Two-requester 16x16 unsigned multiplier built from four passes through a shared external 8x8 multiplier.
// Optional MUL16_SCHED_ZERO_SKIP_EN: a request with a zero operand skips the compute states and answers 0.
module mul16_sched #(
    parameter bit PRIO_INIT = 1'b0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [15:0] req0_a,
    input  logic [15:0] req0_b,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [15:0] req1_a,
    input  logic [15:0] req1_b,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic        rsp_id,
    output logic [31:0] rsp_p,
    output logic [7:0]  m_a,
    output logic [7:0]  m_b,
    input  logic [15:0] m_p,
    output logic        busy
);

    typedef enum logic [2:0] {
        IDLE,
        P0,
        P1,
        P2,
        P3,
        DONE
    } state_t;

    state_t      state, state_nxt;
    logic [15:0] a_q, b_q;
    logic        id_q;
    logic        last_q;
    logic [31:0] acc;

    logic        grant_id;
    logic        accept;
    logic [15:0] sel_a, sel_b;
    logic        zero_op;

    // On a tie the requester not served last wins; otherwise the lone valid requester.
    always_comb begin
        grant_id   = (req0_valid && req1_valid) ? ~last_q : req1_valid;
        req0_ready = rst_n && (state == IDLE) && req0_valid && !grant_id;
        req1_ready = rst_n && (state == IDLE) && req1_valid && grant_id;
        accept     = req0_ready || req1_ready;
        sel_a      = grant_id ? req1_a : req0_a;
        sel_b      = grant_id ? req1_b : req0_b;
`ifdef MUL16_SCHED_ZERO_SKIP_EN
        zero_op    = (sel_a == '0) || (sel_b == '0);
`else
        zero_op    = 1'b0;
`endif
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = zero_op ? DONE : P0;
            P0:      state_nxt = P1;
            P1:      state_nxt = P2;
            P2:      state_nxt = P3;
            P3:      state_nxt = DONE;
            DONE:    if (rsp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        m_a = '0;
        m_b = '0;
        case (state)
            P0: begin m_a = a_q[7:0];  m_b = b_q[7:0];  end
            P1: begin m_a = a_q[15:8]; m_b = b_q[7:0];  end
            P2: begin m_a = a_q[7:0];  m_b = b_q[15:8]; end
            P3: begin m_a = a_q[15:8]; m_b = b_q[15:8]; end
            default: begin m_a = '0; m_b = '0; end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            a_q    <= '0;
            b_q    <= '0;
            id_q   <= 1'b0;
            last_q <= ~PRIO_INIT;
            acc    <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                a_q    <= sel_a;
                b_q    <= sel_b;
                id_q   <= grant_id;
                last_q <= grant_id;
                acc    <= '0;
            end
            // Partial products land at bit 0, 8, 8 and 16; sums wrap mod 2^32.
            case (state)
                P0:      acc <= {16'h0000, m_p};
                P1:      acc <= acc + {8'h00, m_p, 8'h00};
                P2:      acc <= acc + {8'h00, m_p, 8'h00};
                P3:      acc <= acc + {m_p, 16'h0000};
                default: ;
            endcase
        end
    end

    assign rsp_valid = (state == DONE);
    assign rsp_p     = acc;
    assign rsp_id    = id_q;
    assign busy      = (state != IDLE);

endmodule

// File: tb/tb_mul16_sched.sv
// Directed bench for mul16_sched; models the external 8x8 multiplier and checks products, ids, latency.
// Expected zero-operand latency follows MUL16_SCHED_ZERO_SKIP_EN.
module tb_mul16_sched;

    logic        clk;
    logic        rst_n;
    logic        req0_valid, req0_ready;
    logic [15:0] req0_a, req0_b;
    logic        req1_valid, req1_ready;
    logic [15:0] req1_a, req1_b;
    logic        rsp_valid, rsp_ready, rsp_id;
    logic [31:0] rsp_p;
    logic [7:0]  m_a, m_b;
    logic [15:0] m_p;
    logic        busy;

    int n_checks;
    int n_fail;

`ifdef MUL16_SCHED_ZERO_SKIP_EN
    localparam int ZLAT = 1;
`else
    localparam int ZLAT = 5;
`endif

    mul16_sched #(.PRIO_INIT(1'b0)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
        .rsp_p      (rsp_p),
        .m_a        (m_a),
        .m_b        (m_b),
        .m_p        (m_p),
        .busy       (busy)
    );

    // External mul_8bit model
    assign m_p = 16'(m_a) * 16'(m_b);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic run_req(input logic id, input logic [15:0] a, input logic [15:0] b,
                           input logic [31:0] exp_p, input int exp_lat);
        int n;
        int lat;
        @(negedge clk);
        if (id) begin req1_valid = 1'b1; req1_a = a; req1_b = b; end
        else    begin req0_valid = 1'b1; req0_a = a; req0_b = b; end
        n = 0;
        while (!(id ? req1_ready : req0_ready) && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("grant", {31'b0, (id ? req1_ready : req0_ready)}, 32'd1);
        @(posedge clk);
        #1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        if (exp_lat > 1) begin
            check("p0_m_a", {24'b0, m_a}, {24'b0, a[7:0]});
            check("p0_m_b", {24'b0, m_b}, {24'b0, b[7:0]});
        end
        lat = 1;
        while (!rsp_valid && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check("latency", lat, exp_lat);
        check("rsp_p", rsp_p, exp_p);
        check("rsp_id", {31'b0, rsp_id}, {31'b0, id});
        @(posedge clk);
        #1;
        check("idle_after_rsp", {31'b0, busy}, 32'd0);
    endtask

    typedef struct {
        logic        id;
        logic [15:0] a;
        logic [15:0] b;
        logic [31:0] p;
        int          lat;
    } vec_t;

    vec_t vecs[7];

    initial begin
        int n;
        n_checks = 0;
        n_fail   = 0;

        vecs[0] = '{1'b0, 16'h1234, 16'h5678, 32'h06260060, 5};
        vecs[1] = '{1'b1, 16'hFFFF, 16'hFFFF, 32'hFFFE0001, 5};
        vecs[2] = '{1'b0, 16'h00FF, 16'h0100, 32'h0000FF00, 5};
        vecs[3] = '{1'b1, 16'h8000, 16'h0002, 32'h00010000, 5};
        vecs[4] = '{1'b0, 16'h0101, 16'h0101, 32'h00010201, 5};
        vecs[5] = '{1'b1, 16'h0000, 16'hABCD, 32'h00000000, ZLAT};
        vecs[6] = '{1'b0, 16'hABCD, 16'h0001, 32'h0000ABCD, 5};

        rst_n      = 1'b0;
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        req0_a = '0; req0_b = '0; req1_a = '0; req1_b = '0;
        rsp_ready  = 1'b1;
        #3;
        check("rst_busy", {31'b0, busy}, 32'd0);
        check("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
        check("rst_rsp_p", rsp_p, 32'd0);
        check("rst_m_a", {24'b0, m_a}, 32'd0);
        check("rst_ready0", {31'b0, req0_ready}, 32'd0);
        check("rst_ready1", {31'b0, req1_ready}, 32'd0);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 7; i++)
            run_req(vecs[i].id, vecs[i].a, vecs[i].b, vecs[i].p, vecs[i].lat);

        // Both requesters valid continuously: PRIO_INIT=0 serves 0,1,0,1.
        apply_reset();
        @(negedge clk);
        req0_a = 16'h1234; req0_b = 16'h5678;
        req1_a = 16'h0F0F; req1_b = 16'h00F0;
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        #1;
        check("tie_ready0", {31'b0, req0_ready}, 32'd1);
        check("tie_ready1", {31'b0, req1_ready}, 32'd0);
        for (int k = 0; k < 4; k++) begin
            n = 0;
            while (!rsp_valid && n < 20) begin
                @(posedge clk);
                #1;
                n++;
            end
            check("rr_valid", {31'b0, rsp_valid}, 32'd1);
            check("rr_id", {31'b0, rsp_id}, (k % 2));
            check("rr_p", rsp_p, (k % 2 == 0) ? 32'h06260060 : 32'h000E1E10);
            @(posedge clk);
            #1;
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;

        // Response back-pressure for three cycles in DONE.
        @(negedge clk);
        rsp_ready  = 1'b0;
        req0_a = 16'hFFFF; req0_b = 16'h0002;
        req0_valid = 1'b1;
        @(posedge clk);
        #1;
        n = 0;
        while (!rsp_valid && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            #1;
            check("stall_valid", {31'b0, rsp_valid}, 32'd1);
            check("stall_p", rsp_p, 32'h0001FFFE);
            check("stall_id", {31'b0, rsp_id}, 32'd0);
            check("stall_ready0", {31'b0, req0_ready}, 32'd0);
            check("stall_busy", {31'b0, busy}, 32'd1);
        end
        rsp_ready  = 1'b1;
        req0_valid = 1'b0;
        @(posedge clk);
        #1;
        check("release_busy", {31'b0, busy}, 32'd0);
        check("release_valid", {31'b0, rsp_valid}, 32'd0);

        // Reset pulsed while in P2.
        @(negedge clk);
        req1_a = 16'h1111; req1_b = 16'h2222;
        req1_valid = 1'b1;
        @(posedge clk);
        #1;
        req1_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2;
        check("p2_m_a", {24'b0, m_a}, 32'h11);
        check("p2_m_b", {24'b0, m_b}, 32'h22);
        rst_n      = 1'b0;
        req1_valid = 1'b1;
        #1;
        check("midrst_busy", {31'b0, busy}, 32'd0);
        check("midrst_m_a", {24'b0, m_a}, 32'd0);
        check("midrst_p", rsp_p, 32'd0);
        check("midrst_ready1", {31'b0, req1_ready}, 32'd0);
        n = 0;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk);
            #1;
            if (rsp_valid) n++;
        end
        check("midrst_no_rsp", n, 32'd0);
        @(negedge clk);
        req1_valid = 1'b0;
        rst_n      = 1'b1;
        run_req(1'b0, 16'h0003, 16'h0007, 32'h00000015, 5);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
